// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port word memory behind a valid/ready request
// interface. Each accepted request passes through a programmable number of
// wait states, performs exactly one memory access, then returns a one-cycle
// response pulse carrying read data and an out-of-range error flag.

module data_memory_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_error
);

    localparam int          NUM_BYTES = DATA_WIDTH / 8;
    localparam int          ADDR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_wait_cnt;
    logic                   r_ready;
    logic                   r_resp_valid;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_error;

    // Request fields captured on the accept edge
    logic                   r_write;
    logic [31:0]            r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [NUM_BYTES-1:0]   r_be;

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

    logic                   w_in_range;
    logic [ADDR_BITS-1:0]   w_mem_idx;
    logic                   w_exec;
    logic                   w_do_write;

    // Full 32-bit compare so large addresses never alias onto real words
    assign w_in_range = (r_addr < DEPTH_W);
    assign w_mem_idx  = r_addr[ADDR_BITS-1:0];
    assign w_exec     = (r_state == ACCESS) && (r_wait_cnt == 4'd0);
    // A reset on the execute edge wins, so the write is suppressed too
    assign w_do_write = reset_n && w_exec && w_in_range && r_write;

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_error = r_error;

    // Control FSM: accept, count wait states, execute, pulse the response
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            r_state      <= IDLE;
            r_wait_cnt   <= 4'd0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && r_ready) begin
                        r_write    <= req_write;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_be       <= req_be;
                        r_wait_cnt <= WAIT_LOAD;
                        r_ready    <= 1'b0;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end else begin
                        r_error      <= ~w_in_range;
                        r_rdata      <= (w_in_range && !r_write) ? r_mem[w_mem_idx] : '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    // Byte-masked write into storage on the execute edge
    always_ff @(posedge clock) begin
        // NOTE: storage has no reset; contents survive reset and map to plain RAM.
        if (w_do_write) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (r_be[b]) begin
                    r_mem[w_mem_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a transaction-level model (memory array plus
// "outstanding request with a due edge") is advanced on every rising edge and
// compared against the DUT on every falling edge; directed sequences add
// hand-computed literal expectations. A second instance with WAIT_CYCLES=0
// covers back-to-back throughput and ignored requests while busy.

module tb_data_memory_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int WAIT  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main DUT (default parameters)
    logic        reset_n, req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;

    data_memory_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) u_dut (
        .clock(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    // Second DUT with zero wait states
    logic        b_reset_n, b_valid, b_ready, b_write;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_be;
    logic        b_resp_valid, b_error;
    logic [31:0] b_rdata;

    data_memory_ctrl #(.DATA_WIDTH(DW), .DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
        .clock(clk), .reset_n(b_reset_n),
        .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
        .resp_valid(b_resp_valid), .resp_rdata(b_rdata), .resp_error(b_error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h0000_005A;
    endfunction

    // ---------------- transaction-level model ----------------
    logic [31:0] m_mem [DEPTH];
    logic        m_live = 1'b0;
    logic        m_ready, m_resp, m_err, m_pend;
    logic [31:0] m_rdata;
    int          m_cyc = 0;
    int          m_due;
    logic        m_w;
    logic [31:0] m_a, m_d;
    logic [3:0]  m_be;

    task automatic model_step();
        logic was_ready;
        m_cyc++;
        if (reset_n === 1'b0) begin
            m_live  = 1'b1;
            m_pend  = 1'b0;
            m_resp  = 1'b0;
            m_rdata = '0;
            m_err   = 1'b0;
            m_ready = 1'b1;
        end else if (m_live) begin
            was_ready = m_ready;
            m_resp    = 1'b0;
            if (m_pend && m_cyc == m_due) begin
                m_pend = 1'b0;
                m_resp = 1'b1;
                m_err  = !(m_a < 32'(DEPTH));
                m_rdata = '0;
                if (!m_err && m_w) begin
                    for (int b = 0; b < 4; b++)
                        if (m_be[b]) m_mem[m_a][b*8 +: 8] = m_d[b*8 +: 8];
                end else if (!m_err) begin
                    m_rdata = m_mem[m_a];
                end
            end
            if (was_ready && req_valid) begin
                m_pend = 1'b1;
                m_due  = m_cyc + 1 + WAIT;
                m_w    = req_write;
                m_a    = req_addr;
                m_d    = req_wdata;
                m_be   = req_be;
            end
            m_ready = !m_pend && !m_resp;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: every falling edge once the model is synchronised
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check("req_ready", req_ready, m_ready);
            check("resp_valid", resp_valid, m_resp);
            check("resp_rdata", resp_rdata, m_rdata);
            check("resp_error", resp_error, m_err);
        end
    end

    // Watchdog
    initial begin
        #300_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Issue one request and wait for its response; lat counts edges from the
    // accept edge to the edge at which resp_valid is first seen high.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rd,
                          output logic er, output int lat);
        int t;
        t = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", t < 50, 1);
        @(posedge clk);
        lat = 1;
        t = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (resp_valid !== 1'b1 && t < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            t++;
        end
        check("resp_wait", t < 40, 1);
        rd = resp_rdata;
        er = resp_error;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, t, nresp, na, nr;
        int          acc [4];
        int          rsp [4];
        logic        rdy;

        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        b_reset_n = 1'b0; b_valid = 1'b0; b_write = 1'b1;
        b_addr = 32'd1; b_wdata = 32'h1234_5678; b_be = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1; b_reset_n = 1'b1;

        // Reset state
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_error", resp_error, 0);

        // Fill the whole memory with a known pattern
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b1, 32'(i), pat(i), 4'hF, rd, er, lat);
        end

        // Basic write then read, latency 4
        do_req(1'b1, 32'd2, 32'd256, 4'hF, rd, er, lat);
        check("w2_lat", lat, 4);
        check("w2_rdata", rd, 0);
        check("w2_error", er, 0);
        do_req(1'b0, 32'd2, 32'd0, 4'h0, rd, er, lat);
        check("r2_lat", lat, 4);
        check("r2_rdata", rd, 256);
        check("r2_error", er, 0);

        // Byte-enable merge
        do_req(1'b1, 32'd5, 32'hAABB_CCDD, 4'hF, rd, er, lat);
        do_req(1'b1, 32'd5, 32'h1122_3344, 4'b0101, rd, er, lat);
        do_req(1'b0, 32'd5, 32'd0, 4'h0, rd, er, lat);
        check("r5_merge", rd, 32'hAA22_CC44);

        // Zero byte enables: completes, no change
        do_req(1'b1, 32'd7, 32'hDEAD_BEEF, 4'h0, rd, er, lat);
        check("be0_error", er, 0);
        do_req(1'b0, 32'd7, 32'd0, 4'h0, rd, er, lat);
        check("be0_rdata", rd, pat(7));

        // Out of range accesses
        do_req(1'b0, 32'd300, 32'd0, 4'h0, rd, er, lat);
        check("oor_rd_error", er, 1);
        check("oor_rd_rdata", rd, 0);
        do_req(1'b1, 32'hFFFF_FFFF, 32'h0BAD_F00D, 4'hF, rd, er, lat);
        check("oor_wr_error", er, 1);
        check("oor_wr_rdata", rd, 0);
        do_req(1'b1, 32'd256, 32'h0BAD_F00D, 4'hF, rd, er, lat);
        check("oor_256_error", er, 1);

        // Full-depth readback of known contents
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b0, 32'(i), 32'd0, 4'h0, rd, er, lat);
            if (i == 2)      check("rb_2", rd, 256);
            else if (i == 5) check("rb_5", rd, 32'hAA22_CC44);
            else             check("rb_word", rd, pat(i));
        end

        // Reset one edge after acceptance aborts the write
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd20;
        req_wdata = 32'd161; req_be = 4'hF;
        t = 0;
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("abort_accept_wait", t < 50, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        nresp = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid === 1'b1) nresp++;
            @(negedge clk);
        end
        check("abort_no_resp", nresp, 0);
        do_req(1'b0, 32'd20, 32'd0, 4'h0, rd, er, lat);
        check("abort_prior", rd, pat(20));

        // WAIT_CYCLES=0: req_valid held high -> one accept every 3 edges
        @(negedge clk);
        b_valid = 1'b1;
        na = 0;
        nr = 0;
        for (int e = 0; e < 12; e++) begin
            rdy = b_ready;
            @(posedge clk);
            if (rdy === 1'b1) begin
                if (na < 4) acc[na] = e;
                na++;
            end
            @(negedge clk);
            if (b_resp_valid === 1'b1) begin
                if (nr < 4) rsp[nr] = e;
                nr++;
            end
        end
        b_valid = 1'b0;
        check("w0_accepts", na, 4);
        check("w0_resps", nr, 4);
        for (int i = 0; i < 4; i++) begin
            check("w0_accept_edge", acc[i], 3 * i);
            check("w0_resp_edge", rsp[i], 3 * i + 1);
        end

        // Pulse req_valid during ACCESS/RESP: only the first is accepted
        @(negedge clk);
        b_valid = 1'b1;
        t = 0;
        while (b_ready !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("w0_pulse_wait", t < 10, 1);
        @(posedge clk);
        @(negedge clk);
        check("w0_busy_access", b_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("w0_resp_pulse", b_resp_valid, 1);
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        check("w0_back_idle", b_ready, 1);
        nresp = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b_resp_valid === 1'b1) nresp++;
        end
        check("w0_no_extra_resp", nresp, 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
